// File: rtl/out_sig_monitor.sv
// Output-signature monitor: folds sampled DUT output words into a 32-bit CRC-style signature.
// Optional compare-against-expected port pair is enabled by defining OUT_SIG_MONITOR_CMP_EN.
`timescale 1ns/1ps
module out_sig_monitor #(
    parameter int          OUT_W       = 330,
    parameter int          NUM_SAMPLES = 100,
    parameter logic [31:0] SIG_SEED    = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_en,
    input  logic [OUT_W-1:0] out_flat,
    output logic             busy,
    output logic [15:0]      sample_cnt,
    output logic             sig_valid,
    input  logic             sig_ready,
    output logic [31:0]      sig_data
`ifdef OUT_SIG_MONITOR_CMP_EN
    ,
    input  logic [31:0]      exp_sig,
    output logic             mismatch
`endif
);

    localparam int          CHUNKS   = (OUT_W + 31) / 32;
    localparam int          PAD_W    = CHUNKS * 32;
    localparam logic [31:0] POLY     = 32'h04C11DB7;
    localparam logic [15:0] LAST_CNT = 16'(NUM_SAMPLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] sig_p1;
    logic [15:0] cnt_p1;
    logic [31:0] sig_data_p1;
    logic [31:0] fold_p0;
    logic [31:0] sig_next_p0;
    logic        vld_p0;
    logic        last_p0;
    logic        run_start;
    logic        handshake;

    // Chunks are taken from bit 0 upward; the top chunk is zero-extended.
    function automatic logic [31:0] fold_chunks(input logic [OUT_W-1:0] word);
        logic [PAD_W-1:0] padded;
        logic [31:0]      acc;
        padded            = '0;
        padded[OUT_W-1:0] = word;
        acc               = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            acc = acc ^ padded[i*32 +: 32];
        end
        return acc;
    endfunction

    function automatic logic [31:0] crc_step(input logic [31:0] sig, input logic [31:0] f);
        logic [31:0] shifted;
        shifted = {sig[30:0], 1'b0};
        if (sig[31]) begin
            shifted = shifted ^ POLY;
        end
        return shifted ^ f;
    endfunction

    assign run_start = (state_q == IDLE) && start;
    assign handshake = (state_q == REPORT) && sig_ready;

    // Stage p0: fold the sampled word and form the next signature.
    assign fold_p0     = fold_chunks(out_flat);
    assign sig_next_p0 = crc_step(sig_p1, fold_p0);
    assign vld_p0      = (state_q == COLLECT) && sample_en && (cnt_p1 != LAST_CNT);
    assign last_p0     = vld_p0 && ((cnt_p1 + 16'd1) == LAST_CNT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (last_p0) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (handshake) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stage p1: signature, sample count and published signature registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_p1      <= SIG_SEED;
            cnt_p1      <= '0;
            sig_data_p1 <= '0;
        end else if (run_start) begin
            sig_p1 <= SIG_SEED;
            cnt_p1 <= '0;
        end else if (vld_p0) begin
            sig_p1 <= sig_next_p0;
            cnt_p1 <= cnt_p1 + 16'd1;
            if (last_p0) begin
                sig_data_p1 <= sig_next_p0;
            end
        end
    end

`ifdef OUT_SIG_MONITOR_CMP_EN
    logic mismatch_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_p1 <= 1'b0;
        end else if (run_start) begin
            mismatch_p1 <= 1'b0;
        end else if (last_p0) begin
            mismatch_p1 <= (sig_next_p0 != exp_sig);
        end
    end

    assign mismatch = mismatch_p1;
`endif

    assign busy       = (state_q != IDLE);
    assign sig_valid  = (state_q == REPORT);
    assign sample_cnt = cnt_p1;
    assign sig_data   = sig_data_p1;

endmodule

// File: doc/out_sig_monitor.md
OUT_SIG_MONITOR -- requirements
Module: out_sig_monitor

Interface
REQ-001 Parameter OUT_W, default 330: width of the monitored DUT output bus.
REQ-002 Parameter NUM_SAMPLES, default 100: samples folded into one signature, legal range 1..2^16-1.
REQ-003 Parameter SIG_SEED, default 32'hFFFFFFFF: signature register value at start of collection.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  one-cycle pulse that begins a collection run.
REQ-007 sample_en  input  1  out_flat is sampled this cycle when high.
REQ-008 out_flat  input  OUT_W  DUT output word under observation.
REQ-009 busy  output  1  high in COLLECT and REPORT states.
REQ-010 sample_cnt  output  16  number of samples folded in the current run.
REQ-011 sig_valid  output  1  signature available.
REQ-012 sig_ready  input  1  consumer accepts signature.
REQ-013 sig_data  output  32  final signature.

Function
REQ-014 FSM states IDLE, COLLECT, REPORT; IDLE->COLLECT on start; COLLECT->REPORT on the sample making sample_cnt equal NUM_SAMPLES; REPORT->IDLE on sig_valid&&sig_ready.
REQ-015 On IDLE->COLLECT: sig register loads SIG_SEED, sample_cnt clears to 0.
REQ-016 Fold: out_flat split into ceil(OUT_W/32) 32-bit chunks from bit 0 upward, last chunk zero-extended, all chunks XORed to 32-bit F.
REQ-017 Per sample in COLLECT: sig <= {sig[30:0],1'b0} ^ (sig[31] ? 32'h04C11DB7 : 0) ^ F; sample_cnt increments by 1.
REQ-018 sample_en low in COLLECT: sig and sample_cnt hold.
REQ-019 sig_valid rises the cycle after the final sample edge; sig_data equals sig and stays stable while sig_valid high and sig_ready low.
REQ-020 sig_valid deasserts the cycle after the handshake edge; sig_data holds its last value in IDLE.
REQ-021 start while busy is ignored; start and handshake in the same REPORT cycle: handshake completes, start ignored.
REQ-022 sample_en in IDLE or REPORT has no effect.
REQ-023 sample_cnt saturates at NUM_SAMPLES, never wraps.

Reset
REQ-024 rst high at a rising edge forces IDLE, busy=0, sig_valid=0, sample_cnt=0, sig_data=0, sig register=SIG_SEED, regardless of state.
REQ-025 rst during COLLECT or REPORT aborts the run; no signature is emitted for it.
REQ-026 start sampled together with rst is ignored.

Configuration
REQ-027 Macro OUT_SIG_MONITOR_CMP_EN defined: adds input exp_sig[31:0] and output mismatch (1 bit); mismatch = (sig != exp_sig), registered, updated the same edge sig_valid rises, held until next start or rst, reset value 0.
REQ-028 Macro undefined: exp_sig and mismatch ports absent; all other behaviour identical.

Verification
REQ-029 NUM_SAMPLES=1, out_flat=0, start then sample_en one cycle -> sig_valid next cycle, sig_data=32'hFB3EE249, sample_cnt=1.
REQ-030 NUM_SAMPLES=2, out_flat=0 with sample_en alternating 1,0,1 -> sig_valid only after second enabled sample, sample_cnt=2.
REQ-031 REPORT with sig_ready low 5 cycles then high -> sig_valid high for 6 cycles, sig_data constant, IDLE after handshake.
REQ-032 rst pulse at sample 50 of 100 -> busy=0, sample_cnt=0, sig_valid never asserts; new start gives signature identical to a clean run.
REQ-033 start pulsed during COLLECT at sample 10 -> no restart, sample_cnt continues 11,12,...
REQ-034 With OUT_SIG_MONITOR_CMP_EN, case of REQ-029 with exp_sig=32'hFB3EE249 -> mismatch=0; exp_sig=0 -> mismatch=1.
